// File: rtl/logic_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus driving the registered function
// F = ~((((D&C)^B)&A) | (B&~C)) of the owner's operands, with a turnaround cycle between owners.
module logic_bus_arbiter #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CHANNELS-1:0]           req,
   input  logic [CHANNELS*WIDTH-1:0]     a_in,
   input  logic [CHANNELS*WIDTH-1:0]     b_in,
   input  logic [CHANNELS*WIDTH-1:0]     c_in,
   input  logic [CHANNELS*WIDTH-1:0]     d_in,
   output logic [CHANNELS-1:0]           gnt,
   output logic [$clog2(CHANNELS)-1:0]   owner,
   output logic                          bus_oe,
   output logic [WIDTH-1:0]              bus_q
);

   localparam int OW = $clog2(CHANNELS);
   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRIVE = 2'd1;
   localparam logic [1:0] TURN  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] data_r;
   logic [HW-1:0]    hold_cnt;
   logic [OW-1:0]    winner;
   logic [OW-1:0]    cand;
   logic [OW-1:0]    sel;
   logic             found;
   int               wrap_idx;
   logic [WIDTH-1:0] a_ch [CHANNELS];
   logic [WIDTH-1:0] b_ch [CHANNELS];
   logic [WIDTH-1:0] c_ch [CHANNELS];
   logic [WIDTH-1:0] d_ch [CHANNELS];
   logic [WIDTH-1:0] f_sel;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         a_ch[i] = a_in[i*WIDTH +: WIDTH];
         b_ch[i] = b_in[i*WIDTH +: WIDTH];
         c_ch[i] = c_in[i*WIDTH +: WIDTH];
         d_ch[i] = d_in[i*WIDTH +: WIDTH];
      end
   end

   // Search begins just after the last owner so it gets lowest priority.
   always_comb begin
      winner   = owner;
      found    = 1'b0;
      wrap_idx = 0;
      cand     = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         wrap_idx = (int'(owner) + i) % CHANNELS;
         cand     = OW'(wrap_idx);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign sel   = (state == IDLE) ? winner : owner;
   assign f_sel = ~((((d_ch[sel] & c_ch[sel]) ^ b_ch[sel]) & a_ch[sel]) | (b_ch[sel] & ~c_ch[sel]));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         bus_oe   <= 1'b0;
         data_r   <= '0;
         hold_cnt <= '0;
         owner    <= OW'(CHANNELS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt      <= {{(CHANNELS-1){1'b0}}, 1'b1} << winner;
                  owner    <= winner;
                  data_r   <= f_sel;
                  hold_cnt <= '0;
                  bus_oe   <= 1'b1;
                  state    <= DRIVE;
               end
            end
            DRIVE: begin
               if (req[owner] && (hold_cnt < HOLD_LAST)) begin
                  data_r   <= f_sel;
                  hold_cnt <= hold_cnt + 1'b1;
               end else begin
                  gnt    <= '0;
                  bus_oe <= 1'b0;
                  state  <= TURN;
               end
            end
            TURN: begin
               state <= IDLE;
            end
            default: begin
               gnt    <= '0;
               bus_oe <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus_q = bus_oe ? data_r : {WIDTH{1'bz}};

endmodule
